ps2_mouse_writer: RTL and testbench

Receives 3-byte PS/2 mouse packets, accumulates a clamped screen cursor position, and writes X, Y and button state into the mouse memory through its write port. It is the producer for the mouse memory region that the ARM core reads through the memory decoder. It closes the loop so software polling that region sees live mouse data.

---
 rtl/mouse_pkg.sv | 56 +++++
 rtl/ps2_rx.sv | 107 ++++++++++
 rtl/ps2_mouse_writer.sv | 184 ++++++++++++++++++
 tb/tb_ps2_mouse_writer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse writer: packet FSM states,
// mouse memory word addresses, status-byte bit positions and position clamping.
package mouse_pkg;

    localparam int unsigned POS_W  = 16;
    localparam int unsigned ACC_W  = 18;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        B1,
        B2,
        UPD,
        WX,
        WY,
        WB
    } state_t;

    localparam logic [ADDR_W-1:0] MOUSE_ADDR_X   = 2'd0;
    localparam logic [ADDR_W-1:0] MOUSE_ADDR_Y   = 2'd1;
    localparam logic [ADDR_W-1:0] MOUSE_ADDR_BTN = 2'd2;

    localparam int unsigned BTN_L   = 0;
    localparam int unsigned BTN_R   = 1;
    localparam int unsigned BTN_M   = 2;
    localparam int unsigned ALWAYS1 = 3;
    localparam int unsigned XS      = 4;
    localparam int unsigned YS      = 5;
    localparam int unsigned XO      = 6;
    localparam int unsigned YO      = 7;

    // Status byte fields kept after the sync bit has been checked.
    typedef struct packed {
        logic       y_ovf;
        logic       x_ovf;
        logic       y_sign;
        logic       x_sign;
        logic [2:0] btn;
    } mouse_status_t;

    // Clamp a signed intermediate position into [0, size-1].
    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [ACC_W-1:0] v,
                                                   input int unsigned size);
        logic signed [ACC_W-1:0] hi;
        hi = $signed(ACC_W'(size - 1));
        if (v < 0) begin
            return '0;
        end else if (v > hi) begin
            return POS_W'(size - 1);
        end else begin
            return POS_W'(v);
        end
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: pad synchronisers, falling-edge sampling, 11-bit frame
// checks and idle watchdog. Parity checking is enabled by MOUSE_PARITY_CHECK_EN.
module ps2_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W = 4;

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_d;
    logic             fall_c;
    logic             bit_c;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       shreg;
    logic [WD_W-1:0]  wd_cnt;
`ifdef MOUSE_PARITY_CHECK_EN
    logic             par_bit;
`endif

    // Two-flop synchronisers; idle level of both lines is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_d     <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_d     <= clk_sync[1];
        end
    end

    assign fall_c = clk_d & ~clk_sync[1];
    assign bit_c  = data_sync[1];

    // Frame sequencer: bit 0 start, 1..8 data, 9 parity, 10 stop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            wd_cnt     <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
`ifdef MOUSE_PARITY_CHECK_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            byte_valid <= 1'b0;
            err        <= 1'b0;
            if (fall_c) begin
                wd_cnt <= '0;
                case (bit_cnt)
                    CNT_W'(0): begin
                        if (!bit_c) begin
                            bit_cnt <= CNT_W'(1);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    CNT_W'(9): begin
`ifdef MOUSE_PARITY_CHECK_EN
                        par_bit <= bit_c;
`endif
                        bit_cnt <= CNT_W'(10);
                    end
                    CNT_W'(10): begin
                        bit_cnt <= '0;
                        if (!bit_c) begin
                            err <= 1'b1;
`ifdef MOUSE_PARITY_CHECK_EN
                        end else if (!(^{shreg, par_bit})) begin
                            err <= 1'b1;
`endif
                        end else begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end
                    end
                    default: begin
                        shreg   <= {bit_c, shreg[7:1]};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                endcase
            end else if (bit_cnt != '0) begin
                if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    wd_cnt  <= '0;
                    bit_cnt <= '0;
                    err     <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_writer.sv
// Turns 3-byte PS/2 mouse packets into clamped X/Y and button writes to the
// mouse memory. MOUSE_PARITY_CHECK_EN enables parity rejection in the receiver.
module ps2_mouse_writer
    import mouse_pkg::*;
#(
    parameter int unsigned SCREEN_W       = 640,
    parameter int unsigned SCREEN_H       = 480,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              frame_err
);

    logic [7:0]              rx_byte;
    logic                    rx_valid;
    logic                    rx_err;

    logic [7:0]              hold_byte;
    logic                    hold_valid;
    logic                    consume_c;

    state_t                  state, state_nxt;
    mouse_status_t           status_q, status_nxt;
    logic [7:0]              dx_q, dx_nxt;
    logic [7:0]              dy_q, dy_nxt;
    logic [POS_W-1:0]        x_pos, x_nxt;
    logic [POS_W-1:0]        y_pos, y_nxt;
    logic [2:0]              btn_q, btn_nxt;
    logic                    we_nxt;
    logic [ADDR_W-1:0]       addr_nxt;
    logic [DATA_W-1:0]       wdata_nxt;

    logic [8:0]              dx9_c, dy9_c;
    logic signed [ACC_W-1:0] x_sum_c, y_sum_c;
    logic [POS_W-1:0]        x_clamp_c, y_clamp_c;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .err        (rx_err)
    );

    assign frame_err = rx_err;

    // Single-entry holding register; a new byte overwrites an unconsumed one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_byte  <= '0;
            hold_valid <= 1'b0;
        end else if (rx_valid) begin
            hold_byte  <= rx_byte;
            hold_valid <= 1'b1;
        end else if (consume_c) begin
            hold_valid <= 1'b0;
        end
    end

    // Deltas are 9-bit two's complement; overflow flags zero them.
    always_comb begin
        dx9_c     = status_q.x_ovf ? 9'd0 : {status_q.x_sign, dx_q};
        dy9_c     = status_q.y_ovf ? 9'd0 : {status_q.y_sign, dy_q};
        x_sum_c   = $signed({2'b00, x_pos}) + $signed({{(ACC_W-9){dx9_c[8]}}, dx9_c});
        y_sum_c   = $signed({2'b00, y_pos}) - $signed({{(ACC_W-9){dy9_c[8]}}, dy9_c});
        x_clamp_c = clamp_pos(x_sum_c, SCREEN_W);
        y_clamp_c = clamp_pos(y_sum_c, SCREEN_H);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            status_q  <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            x_pos     <= POS_W'(SCREEN_W / 2);
            y_pos     <= POS_W'(SCREEN_H / 2);
            btn_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            status_q  <= status_nxt;
            dx_q      <= dx_nxt;
            dy_q      <= dy_nxt;
            x_pos     <= x_nxt;
            y_pos     <= y_nxt;
            btn_q     <= btn_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
        end
    end

    // Write-port registers are loaded one state early so the strobe lines up with WX/WY/WB.
    always_comb begin
        state_nxt  = state;
        status_nxt = status_q;
        dx_nxt     = dx_q;
        dy_nxt     = dy_q;
        x_nxt      = x_pos;
        y_nxt      = y_pos;
        btn_nxt    = btn_q;
        consume_c  = 1'b0;
        we_nxt     = 1'b0;
        addr_nxt   = mem_addr;
        wdata_nxt  = mem_wdata;

        case (state)
            IDLE: begin
                if (hold_valid) begin
                    consume_c = 1'b1;
                    if (hold_byte[ALWAYS1]) begin
                        status_nxt.y_ovf  = hold_byte[YO];
                        status_nxt.x_ovf  = hold_byte[XO];
                        status_nxt.y_sign = hold_byte[YS];
                        status_nxt.x_sign = hold_byte[XS];
                        status_nxt.btn    = {hold_byte[BTN_M], hold_byte[BTN_R], hold_byte[BTN_L]};
                        state_nxt         = B1;
                    end
                end
            end
            B1: begin
                if (hold_valid) begin
                    consume_c = 1'b1;
                    dx_nxt    = hold_byte;
                    state_nxt = B2;
                end
            end
            B2: begin
                if (hold_valid) begin
                    consume_c = 1'b1;
                    dy_nxt    = hold_byte;
                    state_nxt = UPD;
                end
            end
            UPD: begin
                x_nxt     = x_clamp_c;
                y_nxt     = y_clamp_c;
                btn_nxt   = status_q.btn;
                we_nxt    = 1'b1;
                addr_nxt  = MOUSE_ADDR_X;
                wdata_nxt = DATA_W'(x_clamp_c);
                state_nxt = WX;
            end
            WX: begin
                we_nxt    = 1'b1;
                addr_nxt  = MOUSE_ADDR_Y;
                wdata_nxt = DATA_W'(y_pos);
                state_nxt = WY;
            end
            WY: begin
                we_nxt    = 1'b1;
                addr_nxt  = MOUSE_ADDR_BTN;
                wdata_nxt = {{(DATA_W-3){1'b0}}, btn_q};
                state_nxt = WB;
            end
            WB: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

`ifdef MOUSE_PARITY_CHECK_EN
        if (rx_err && (state == IDLE || state == B1 || state == B2)) begin
            state_nxt = IDLE;
        end
`endif
    end

endmodule

// File: tb/tb_ps2_mouse_writer.sv
// Scoreboard bench for ps2_mouse_writer: drives PS/2 frames, models the cursor,
// and checks every memory write and frame_err pulse. Honours MOUSE_PARITY_CHECK_EN.
module tb_ps2_mouse_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        mem_we;
    logic [1:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        frame_err;

    typedef struct packed {
        logic [1:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  e;
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0;
    int   err_exp = 0;
    int   run_len = 0;
    int   mx = 320;
    int   my = 240;

    always #5 clk = ~clk;

    ps2_mouse_writer dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: pops expected writes and checks strobe run length.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_err) err_seen++;
            if (mem_we) begin
                run_len++;
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 32'(mem_we), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("addr", 32'(mem_addr), 32'(e.a));
                    check("wdata", mem_wdata, e.d);
                end
            end else begin
                if (run_len != 0) check("we_run_len", run_len, 3);
                run_len = 0;
            end
        end
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (15) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (30) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (15) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
        logic [10:0] f;
        f = {stop, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        repeat (40) @(posedge clk);
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_packet(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
        int dxv, dyv;
        dxv = s[6] ? 0 : (s[4] ? int'(dx) - 256 : int'(dx));
        dyv = s[7] ? 0 : (s[5] ? int'(dy) - 256 : int'(dy));
        mx = clampi(mx + dxv, 639);
        my = clampi(my - dyv, 479);
        exp_q.push_back('{a: 2'd0, d: 32'(mx)});
        exp_q.push_back('{a: 2'd1, d: 32'(my)});
        exp_q.push_back('{a: 2'd2, d: {29'd0, s[2:0]}});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic send_packet(input logic [7:0] s, input logic [7:0] dx, input logic [7:0] dy);
        model_packet(s, dx, dy);
        send_frame(s, 1'b0, 1'b1);
        send_frame(dx, 1'b0, 1'b1);
        send_frame(dy, 1'b0, 1'b1);
        drain("packet_drain");
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_err", 32'(frame_err), 0);
        reset = 1'b1;

        repeat (1000) @(posedge clk);
        check("idle_err", err_seen, 0);

        send_packet(8'h09, 8'h0A, 8'h05);
        send_packet(8'h18, 8'h00, 8'h00);
        send_packet(8'h18, 8'h00, 8'h00);

        send_frame(8'h00, 1'b0, 1'b1);
        send_packet(8'h08, 8'h01, 8'h01);

        send_packet(8'h28, 8'h00, 8'h00);
        send_packet(8'hC8, 8'h50, 8'h50);
        send_packet(8'h0E, 8'hFF, 8'h00);
        check("err_after_packets", err_seen, err_exp);

`ifdef MOUSE_PARITY_CHECK_EN
        send_frame(8'h08, 1'b1, 1'b1);
        err_exp++;
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (50) @(posedge clk);
`else
        model_packet(8'h08, 8'h01, 8'h01);
        send_frame(8'h08, 1'b1, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1);
        drain("parity_drain");
`endif
        check("err_parity", err_seen, err_exp);

        send_frame(8'h08, 1'b0, 1'b0);
        err_exp++;
        check("err_bad_stop", err_seen, err_exp);
        send_packet(8'h09, 8'h03, 8'h02);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (50100) @(posedge clk);
        err_exp++;
        check("err_timeout", err_seen, err_exp);
        send_packet(8'h0A, 8'h05, 8'h05);

        repeat (20) @(posedge clk);
        check("err_final", err_seen, err_exp);
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
